msk_rnd_prng: RTL

Fresh-randomness source for the masked AES datapath. It expands a 32-bit-per-word externally supplied seed into a new `RW`-bit random vector every consumed cycle. It sits directly upstream of the bank of HPC2 masked AND gadgets in the S-box and drives their `rnd` inputs. One `hpc2rnd = d*(d-1)/2` slice goes to each gadget, and every slice is fresh each cycle the core runs.

---
 rtl/msk_rnd_prng.sv | 94 +++++++++
 1 files changed

// File: rtl/msk_rnd_prng.sv
// msk_rnd_prng: LFSR-based fresh-randomness source for HPC2 masked AND gadgets
module msk_rnd_prng #(
    parameter int d        = 2,
    parameter int NGADGETS = 4,
    parameter int WARMUP   = 64,
    localparam int hpc2rnd = d * (d - 1) / 2,
    localparam int RW      = NGADGETS * hpc2rnd,
    localparam int NLANES  = (RW + 31) / 32,
    localparam int NWORDS  = 2 * NLANES
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [31:0]   seed,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic          reseed,
    output logic [RW-1:0] rnd,
    output logic          rnd_valid,
    input  logic          rnd_ready
);
    localparam int WCW = $clog2(NWORDS) + 1;
    localparam int WW  = $clog2(WARMUP + 2);

    typedef enum logic [1:0] {S_SEED, S_WARM, S_RUN} state_e;

    state_e         state_q;
    logic [WCW-1:0] wc_q;
    logic [WW-1:0]  wcnt_q;
    logic [63:0]    lane_q [NLANES];
    logic [63:0]    seed_d [NLANES];
    logic [63:0]    adv_d  [NLANES];
    logic           last_word;

    function automatic logic [63:0] advance(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        for (int i = 0; i < 32; i++) r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
        return r;
    endfunction

    assign seed_ready = state_q == S_SEED;
    assign rnd_valid  = state_q == S_RUN;
    assign last_word  = int'(wc_q) == NWORDS - 1;

    // Lane contents if the offered seed word is taken, and after one 32-step advance
    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            seed_d[k] = lane_q[k];
            if (int'(wc_q) == 2 * k) seed_d[k][63:32] = seed;
            if (int'(wc_q) == 2 * k + 1) seed_d[k][31:0] = seed;
            adv_d[k] = advance(lane_q[k]);
        end
    end

    // Low 32 bits of each lane form the output; forced to zero outside RUN so seed never leaks
    always_comb begin
        rnd = '0;
        for (int i = 0; i < RW; i++) rnd[i] = rnd_valid & lane_q[i / 32][i % 32];
    end

    // Seeding, warm-up and run control; reseed overrides any word or advance in the same cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_SEED;
            wc_q    <= '0;
            wcnt_q  <= '0;
            for (int k = 0; k < NLANES; k++) lane_q[k] <= '0;
        end else if (reseed) begin
            state_q <= S_SEED;
            wc_q    <= '0;
        end else begin
            case (state_q)
                S_SEED: if (seed_valid) begin
                    if (last_word) begin
                        for (int k = 0; k < NLANES; k++) lane_q[k] <= (seed_d[k] == '0) ? 64'd1 : seed_d[k];
                        wc_q    <= '0;
                        wcnt_q  <= WW'(WARMUP);
                        state_q <= (WARMUP == 0) ? S_RUN : S_WARM;
                    end else begin
                        for (int k = 0; k < NLANES; k++) lane_q[k] <= seed_d[k];
                        wc_q <= wc_q + WCW'(1);
                    end
                end
                S_WARM: begin
                    for (int k = 0; k < NLANES; k++) lane_q[k] <= adv_d[k];
                    wcnt_q <= wcnt_q - WW'(1);
                    if (wcnt_q == WW'(1)) state_q <= S_RUN;
                end
                S_RUN: if (rnd_ready) for (int k = 0; k < NLANES; k++) lane_q[k] <= adv_d[k];
                default: state_q <= S_SEED;
            endcase
        end
    end
endmodule
